// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives a 1-cycle synchronous instruction memory,
// buffers returned words in a 2-entry queue and hands {instr, pc} to decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misalign_o
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [0:0]  state_q;
  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic [1:0]  count_q;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];

  logic       run;
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;
  logic [1:0] level;

  assign run = (state_q == RUN);

  assign instr_valid_o = run && (count_q != 2'd0);
  assign instr_o       = instr_valid_o ? q_instr[0] : NOP_INSTR;
  assign instr_pc_o    = instr_valid_o ? q_pc[0] : 32'h0;
  assign misalign_o    = (state_q == HALT);
  assign imem_addr_o   = pc_q;

  assign pop   = instr_valid_o & instr_ready_i;
  assign occ   = {1'b0, count_q} + {2'b0, inflight_q}
               - {2'b0, pop};
  assign issue = run & ~redirect_i & (occ < 3'd2);
  assign push  = run & inflight_q & ~redirect_i;
  assign level = count_q - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= 2'd0;
    end else if (redirect_i) begin
      // In-flight read and queued words belong to the old path.
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      pc_q       <= redirect_pc_i;
      state_q    <= (redirect_pc_i[1:0] != 2'b00) ? HALT : RUN;
    end else begin
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      if (issue) begin
        pc_q          <= pc_q + 32'd4;
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
      end else begin
        inflight_q <= 1'b0;
      end
    end
  end

  // Head is slot 0; a push after a same-cycle pop lands in the freed slot.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_i) begin
      if (pop) begin
        q_instr[0] <= q_instr[1];
        q_pc[0]    <= q_pc[1];
      end
      if (push) begin
        if (level == 2'd0) begin
          q_instr[0] <= imem_instr_i;
          q_pc[0]    <= inflight_pc_q;
        end else begin
          q_instr[1] <= imem_instr_i;
          q_pc[1]    <= inflight_pc_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, stall, redirect, misalign halt,
// reset priority and PC wrap with a high RESET_PC.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        ready;
  logic        misalign;

  logic        rst2;
  logic [31:0] addr2;
  logic [31:0] imem2;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] ipc2;
  logic        ready2;
  logic        mis2;
  logic        redirect2;
  logic [31:0] redirect_pc2;

  int vectors;
  int miscompares;

  instr_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr_o  (imem_addr),
    .imem_instr_i (imem_instr),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .instr_valid_o(valid),
    .instr_o      (instr),
    .instr_pc_o   (ipc),
    .instr_ready_i(ready),
    .misalign_o   (misalign)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk          (clk),
    .rst          (rst2),
    .imem_addr_o  (addr2),
    .imem_instr_i (imem2),
    .redirect_i   (redirect2),
    .redirect_pc_i(redirect_pc2),
    .instr_valid_o(valid2),
    .instr_o      (instr2),
    .instr_pc_o   (ipc2),
    .instr_ready_i(ready2),
    .misalign_o   (mis2)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    imem_instr <= memw(imem_addr);
    imem2      <= memw(addr2);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] p;
    rst = 1'b1;
    ready = 1'b1;
    step();
    step();
    vectors++;
    if (valid !== 1'b0 || instr !== 32'h13 || ipc !== 32'h0 ||
        misalign !== 1'b0 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: v=%b i=%h pc=%h m=%b a=%h, want 0 13 0 0 0",
               valid, instr, ipc, misalign, imem_addr);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b0 || imem_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL first_issue: v=%b a=%h, want 0 4", valid, imem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      p = 32'(4 * k);
      vectors++;
      if (valid !== 1'b1 || instr !== memw(p) || ipc !== p) begin
        miscompares++;
        $display("FAIL stream[%0d]: v=%b i=%h pc=%h, want 1 %h %h",
                 k, valid, instr, ipc, memw(p), p);
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] p;
    rst = 1'b1;
    ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    step();
    vectors++;
    if (valid !== 1'b1 || ipc !== 32'h4) begin
      miscompares++;
      $display("FAIL stall_pre: v=%b pc=%h, want 1 4", valid, ipc);
    end
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if (valid !== 1'b1 || instr !== memw(32'h4) || ipc !== 32'h4 ||
          imem_addr !== 32'hC) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: v=%b i=%h pc=%h a=%h, want 1 %h 4 c",
                 k, valid, instr, ipc, imem_addr, memw(32'h4));
      end
    end
    ready = 1'b1;
    for (int k = 2; k < 5; k++) begin
      step();
      p = 32'(4 * k);
      vectors++;
      if (valid !== 1'b1 || instr !== memw(p) || ipc !== p) begin
        miscompares++;
        $display("FAIL stall_resume[%0d]: v=%b i=%h pc=%h, want 1 %h %h",
                 k, valid, instr, ipc, memw(p), p);
      end
    end
  endtask

  task automatic test_redirect;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    ready = 1'b0;
    step();
    redirect = 1'b0;
    ready = 1'b1;
    vectors++;
    if (valid !== 1'b0 || imem_addr !== 32'h40 || misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_e0: v=%b a=%h m=%b, want 0 40 0",
               valid, imem_addr, misalign);
    end
    step();
    vectors++;
    if (valid !== 1'b0 || imem_addr !== 32'h44) begin
      miscompares++;
      $display("FAIL redir_e1: v=%b a=%h, want 0 44", valid, imem_addr);
    end
    step();
    vectors++;
    if (valid !== 1'b1 || instr !== memw(32'h40) || ipc !== 32'h40) begin
      miscompares++;
      $display("FAIL redir_e2: v=%b i=%h pc=%h, want 1 %h 40",
               valid, instr, ipc, memw(32'h40));
    end
    step();
    vectors++;
    if (valid !== 1'b1 || instr !== memw(32'h44) || ipc !== 32'h44) begin
      miscompares++;
      $display("FAIL redir_e3: v=%b i=%h pc=%h, want 1 %h 44",
               valid, instr, ipc, memw(32'h44));
    end
  endtask

  task automatic test_misalign;
    redirect = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (misalign !== 1'b1 || valid !== 1'b0 || instr !== 32'h13 ||
          imem_addr !== 32'h42) begin
        miscompares++;
        $display("FAIL halt[%0d]: m=%b v=%b i=%h a=%h, want 1 0 13 42",
                 k, misalign, valid, instr, imem_addr);
      end
      step();
    end
    redirect = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    vectors++;
    if (misalign !== 1'b0 || valid !== 1'b0 || imem_addr !== 32'h80) begin
      miscompares++;
      $display("FAIL unhalt_e0: m=%b v=%b a=%h, want 0 0 80",
               misalign, valid, imem_addr);
    end
    step();
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL unhalt_e1: v=%b, want 0", valid);
    end
    step();
    vectors++;
    if (valid !== 1'b1 || instr !== memw(32'h80) || ipc !== 32'h80) begin
      miscompares++;
      $display("FAIL unhalt_e2: v=%b i=%h pc=%h, want 1 %h 80",
               valid, instr, ipc, memw(32'h80));
    end
    step();
    vectors++;
    if (valid !== 1'b1 || ipc !== 32'h84) begin
      miscompares++;
      $display("FAIL unhalt_e3: v=%b pc=%h, want 1 84", valid, ipc);
    end
  endtask

  task automatic test_reset_wins;
    rst = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    rst = 1'b0;
    redirect = 1'b0;
    vectors++;
    if (valid !== 1'b0 || imem_addr !== 32'h0 || misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL rstwin_e0: v=%b a=%h m=%b, want 0 0 0",
               valid, imem_addr, misalign);
    end
    step();
    vectors++;
    if (valid !== 1'b0 || imem_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL rstwin_e1: v=%b a=%h, want 0 4", valid, imem_addr);
    end
    step();
    vectors++;
    if (valid !== 1'b1 || instr !== memw(32'h0) || ipc !== 32'h0) begin
      miscompares++;
      $display("FAIL rstwin_e2: v=%b i=%h pc=%h, want 1 %h 0",
               valid, instr, ipc, memw(32'h0));
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    exp_pc[3] = 32'h0000_0004;
    ready2 = 1'b1;
    vectors++;
    if (addr2 !== 32'hFFFF_FFF8 || valid2 !== 1'b0 || ipc2 !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_reset: a=%h v=%b pc=%h, want fffffff8 0 0",
               addr2, valid2, ipc2);
    end
    rst2 = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (valid2 !== 1'b1 || instr2 !== memw(exp_pc[k]) ||
          ipc2 !== exp_pc[k]) begin
        miscompares++;
        $display("FAIL wrap[%0d]: v=%b i=%h pc=%h, want 1 %h %h",
                 k, valid2, instr2, ipc2, memw(exp_pc[k]), exp_pc[k]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    rst2 = 1'b1;
    ready2 = 1'b0;
    redirect2 = 1'b0;
    redirect_pc2 = 32'h0;
    test_reset();
    test_stall();
    test_redirect();
    test_misalign();
    test_reset_wins();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
